// File: rtl/bf16_add_sched.sv
// Round-robin scheduler sharing one combinational bfloat16 adder among NREQ requesters.
// Define BF16_SCHED_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module bf16_add_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [15:0]          resp_sum,
   output logic [IDW-1:0]       resp_id
`ifdef BF16_SCHED_STATS_EN
   ,
   output logic [16*NREQ-1:0]   grant_cnt
`endif
);

   // Subnormals are flushed to zero; Inf combined with zero is treated as invalid (NaN).
   function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
      logic       sa, sb, s_big, swap, eff_sub;
      logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      logic [7:0] ea, eb, e_big, e_small, e_diff;
      logic [7:0] m_big, m_small, m_sh, m_dif;
      logic [8:0] m_sum;
      logic [6:0] m_norm;
      logic [3:0] lz;
      logic [15:0] res;

      sa = a[15];
      sb = b[15];
      ea = a[14:7];
      eb = b[14:7];
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (a[6:0] == 7'h00);
      b_inf  = (eb == 8'hFF) && (b[6:0] == 7'h00);
      a_nan  = (ea == 8'hFF) && (a[6:0] != 7'h00);
      b_nan  = (eb == 8'hFF) && (b[6:0] != 7'h00);

      swap    = (b[14:0] > a[14:0]);
      s_big   = swap ? sb : sa;
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      m_big   = swap ? {1'b1, b[6:0]} : {1'b1, a[6:0]};
      m_small = swap ? {1'b1, a[6:0]} : {1'b1, b[6:0]};
      e_diff  = e_big - e_small;
      m_sh    = m_small >> e_diff;
      eff_sub = sa ^ sb;
      m_sum   = {1'b0, m_big} + {1'b0, m_sh};
      m_dif   = m_big - m_sh;

      lz = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (m_dif[i]) lz = 4'(7 - i);
      end
      m_norm = 7'(m_dif << lz);

      res = 16'h0000;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)) ||
          (a_inf && b_zero) || (b_inf && a_zero)) begin
         res = 16'h7FC0;
      end else if (a_inf) begin
         res = a;
      end else if (b_inf) begin
         res = b;
      end else if (a_zero && b_zero) begin
         res = {sa & sb, 15'h0000};
      end else if (a_zero) begin
         res = b;
      end else if (b_zero) begin
         res = a;
      end else if (!eff_sub) begin
         if (m_sum[8]) begin
            if (e_big == 8'hFE) res = {s_big, 8'hFF, 7'h00};
            else                res = {s_big, e_big + 8'd1, m_sum[7:1]};
         end else begin
            res = {s_big, e_big, m_sum[6:0]};
         end
      end else begin
         if (m_dif == 8'h00)               res = 16'h0000;
         else if (e_big <= {4'h0, lz})     res = {s_big, 15'h0000};
         else                              res = {s_big, e_big - {4'h0, lz}, m_norm};
      end
      return res;
   endfunction

   logic                resp_valid_q, resp_valid_d;
   logic [15:0]         resp_sum_q, resp_sum_d;
   logic [IDW-1:0]      resp_id_q, resp_id_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;

   logic                slot_free;
   logic                grant_found;
   logic                grant_fire;
   logic [IDW-1:0]      grant_idx;
   logic [IDW:0]        scan_idx;
   logic [15:0]         sel_a, sel_b;

   // Round-robin search from rr_ptr; grant only when the result slot can take a value.
   always_comb begin
      slot_free   = !resp_valid_q || resp_ready;
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (scan_idx >= (IDW+1)'(NREQ)) scan_idx = scan_idx - (IDW+1)'(NREQ);
         if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[IDW-1:0];
         end
      end
      grant_fire = slot_free && grant_found && !rst;
      req_ready  = grant_fire ? (NREQ'(1) << grant_idx) : '0;
   end

   always_comb begin
      sel_a        = req_a[16*grant_idx +: 16];
      sel_b        = req_b[16*grant_idx +: 16];
      resp_valid_d = resp_valid_q;
      resp_sum_d   = resp_sum_q;
      resp_id_d    = resp_id_q;
      rr_ptr_d     = rr_ptr_q;
      if (grant_fire) begin
         resp_valid_d = 1'b1;
         resp_sum_d   = bf16_add(sel_a, sel_b);
         resp_id_d    = grant_idx;
         rr_ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end else if (resp_valid_q && resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_sum_q   <= 16'h0000;
         resp_id_q    <= '0;
         rr_ptr_q     <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_sum_q   <= resp_sum_d;
         resp_id_q    <= resp_id_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_sum   = resp_sum_q;
   assign resp_id    = resp_id_q;

`ifdef BF16_SCHED_STATS_EN
   logic [NREQ-1:0][15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_fire && (cnt_q[grant_idx] != 16'hFFFF)) begin
         cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/bf16_add_sched.md
BF16_ADD_SCHED -- requirements
Module: bf16_add_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one bfloat16 adder; supported values 2..8.
REQ-002 The block SHALL have parameter IDW, default 2, response ID width; IDW = clog2(NREQ).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, per-requester operation valid.
REQ-006 The block SHALL have port req_a, input, 16*NREQ, operand A of requester i in bits [16i+15:16i] (bfloat16).
REQ-007 The block SHALL have port req_b, input, 16*NREQ, operand B of requester i, packed as req_a.
REQ-008 The block SHALL have port req_ready, output, NREQ, one-hot-or-zero grant; requester i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port resp_valid, output, 1, result register holds a valid sum.
REQ-010 The block SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port resp_sum, output, 16, bfloat16 sum A+B.
REQ-012 The block SHALL have port resp_id, output, IDW, index of the requester that produced resp_sum.

Function
REQ-013 The block SHALL contain exactly one combinational bfloat16 adder (sign/exponent/7-bit fraction, truncating alignment, NaN=0x7FC0-class, Inf, zero special cases), multiplexed among requesters.
REQ-014 The block SHALL have a "slot free" condition: resp_valid low, or resp_valid and resp_ready both high in the same cycle.
REQ-015 The block SHALL drive req_ready combinationally: when slot free and at least one req_valid is high, exactly one bit is high, chosen round-robin starting at rr_ptr; otherwise req_ready is all zero.
REQ-016 The round-robin search SHALL check index rr_ptr, then rr_ptr+1, and so on, modulo NREQ; the first requester with req_valid high wins.
REQ-017 On acceptance of requester g, the block SHALL register the adder output of req_a[g]/req_b[g] into resp_sum, set resp_id=g, set resp_valid=1, and set rr_ptr=(g+1) mod NREQ, all at the next edge; latency is one cycle.
REQ-018 The block SHALL only change rr_ptr on an accepting cycle; idle cycles do not change it.
REQ-019 When resp_valid and resp_ready are high and no request is accepted in that cycle, the block SHALL clear resp_valid at the next edge and hold resp_sum/resp_id.
REQ-020 A response drain and a new acceptance in the same cycle SHALL both take effect: resp_valid stays 1 and the register loads the new sum; sustained throughput is one operation per cycle.
REQ-021 While resp_valid is high and resp_ready is low, resp_sum, resp_id and resp_valid SHALL stay stable, and req_ready SHALL be all zero.
REQ-022 The block SHALL not combinationally depend req_ready on req_a/req_b, and SHALL use req_valid only for grant selection.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL set resp_valid=0, resp_sum=16'h0000, resp_id=0 and rr_ptr=0; req_ready is all zero during that cycle.
REQ-024 Reset asserted while a result is pending SHALL discard that result with no response; the first grant after reset goes to the lowest valid index.

Configuration
REQ-025 With macro BF16_SCHED_STATS_EN defined, the block SHALL add output grant_cnt, 16*NREQ wide: one 16-bit saturating counter per requester, incremented on each acceptance, holding at 16'hFFFF, cleared by rst.
REQ-026 With BF16_SCHED_STATS_EN undefined, the block SHALL omit the grant_cnt port and counters; all other behaviour is identical.

Verification
REQ-027 Single op: reset, then req_valid=4'b0100, A=0x3F80 (1.0), B=0x4000 (2.0), resp_ready=1 -> req_ready=4'b0100; next cycle resp_valid=1, resp_sum=0x4040, resp_id=2.
REQ-028 Fairness: all four req_valid held high, resp_ready=1 -> grants go 0,1,2,3,0,... with one grant per cycle and back-to-back resp_valid.
REQ-029 Backpressure: resp_valid=1, resp_ready=0 for 5 cycles with pending requests -> req_ready=0, resp_sum/resp_id frozen; on resp_ready=1, drain and next grant happen in the same cycle.
REQ-030 Specials via requester 1: A=0x7F80 (+Inf), B=0x0000 -> resp_sum exponent 0xFF with fraction 0x40 (NaN); A=0xBF80, B=0x3F80 -> exponent 0x00, fraction 0x00.
REQ-031 Reset mid-flight: grant requester 3, assert rst next cycle with resp_ready=0 -> resp_valid=0, rr_ptr=0, and the next grant goes to the lowest valid index.
REQ-032 With BF16_SCHED_STATS_EN: 70000 grants to requester 0 -> its grant_cnt field reads 16'hFFFF and other fields read 0.
